// File: rtl/pipe_pkg.sv
// Shared types and default constants for the pipeline stage register and its skid buffer.
package pipe_pkg;

  localparam int          DATA_W_DEF = 64;
  localparam int          CTRL_W_DEF = 9;
  localparam logic [31:0] RESET_PC   = 32'h0040_0000;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } stage_state_e;

endpackage

// File: rtl/pipe_skid_buf.sv
// Second-entry storage for the skid build, plus the steering mux that feeds the output register.
module pipe_skid_buf
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CTRL_W = CTRL_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              load_i,
  input  logic              sel_skid_i,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  output logic [DATA_W-1:0] fwd_data_o,
  output logic [CTRL_W-1:0] fwd_ctrl_o
);

  logic [DATA_W-1:0] skid_data_q;
  logic [CTRL_W-1:0] skid_ctrl_q;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
    end else if (load_i) begin
      skid_data_q <= in_data_i;
      skid_ctrl_q <= in_ctrl_i;
    end
  end

  assign fwd_data_o = sel_skid_i ? skid_data_q : in_data_i;
  assign fwd_ctrl_o = sel_skid_i ? skid_ctrl_q : in_ctrl_i;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register. Define PIPE_STAGE_SKID_EN for the 2-entry skid build
// (registered in_ready); the default build holds a single entry.
//
// state | meaning
// EMPTY | nothing held, out_valid=0
// ONE   | one entry presented on out_*
// FULL  | one entry presented plus one parked in the skid buffer (skid build only)
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W     = DATA_W_DEF,
  parameter int                CTRL_W     = CTRL_W_DEF,
  parameter logic [DATA_W-1:0] RESET_DATA = DATA_W'({RESET_PC, 32'd0})
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  stage_state_e      state_q, state_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [CTRL_W-1:0] out_ctrl_q, out_ctrl_d;
  logic              accept, rel;

  assign accept = in_valid && in_ready;
  assign rel    = out_valid_q && out_ready;

`ifdef PIPE_STAGE_SKID_EN
  logic              in_ready_q, in_ready_d;
  logic              skid_load, fwd_sel;
  logic [DATA_W-1:0] fwd_data;
  logic [CTRL_W-1:0] fwd_ctrl;

  assign in_ready = in_ready_q;

  pipe_skid_buf #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W)
  ) u_skid (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .load_i     (skid_load),
    .sel_skid_i (fwd_sel),
    .in_data_i  (in_data),
    .in_ctrl_i  (in_ctrl),
    .fwd_data_o (fwd_data),
    .fwd_ctrl_o (fwd_ctrl)
  );

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ctrl_d  = out_ctrl_q;
    skid_load   = 1'b0;
    fwd_sel     = 1'b0;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          out_valid_d = 1'b1;
          out_data_d  = fwd_data;
          out_ctrl_d  = fwd_ctrl;
          state_d     = ONE;
        end
      end
      ONE: begin
        if (accept && rel) begin
          out_data_d = fwd_data;
          out_ctrl_d = fwd_ctrl;
        end else if (accept) begin
          skid_load = 1'b1;
          state_d   = FULL;
        end else if (rel) begin
          out_valid_d = 1'b0;
          out_ctrl_d  = '0;
          state_d     = EMPTY;
        end
      end
      FULL: begin
        // in_ready is low here, so the only move is promoting the skid entry
        if (rel) begin
          fwd_sel    = 1'b1;
          out_data_d = fwd_data;
          out_ctrl_d = fwd_ctrl;
          state_d    = ONE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        out_ctrl_d  = '0;
        state_d     = EMPTY;
      end
    endcase
    if (flush) begin
      state_d     = EMPTY;
      out_valid_d = 1'b0;
      out_data_d  = out_data_q;
      out_ctrl_d  = '0;
      skid_load   = 1'b0;
    end
    in_ready_d = (state_d != FULL);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_ready_q <= 1'b1;
    end else begin
      in_ready_q <= in_ready_d;
    end
  end
`else
  assign in_ready = !out_valid_q || out_ready;

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ctrl_d  = out_ctrl_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          out_valid_d = 1'b1;
          out_data_d  = in_data;
          out_ctrl_d  = in_ctrl;
          state_d     = ONE;
        end
      end
      ONE: begin
        // accepting while ONE implies out_ready, so the held entry leaves the same edge
        if (accept) begin
          out_data_d = in_data;
          out_ctrl_d = in_ctrl;
        end else if (rel) begin
          out_valid_d = 1'b0;
          out_ctrl_d  = '0;
          state_d     = EMPTY;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        out_ctrl_d  = '0;
        state_d     = EMPTY;
      end
    endcase
    if (flush) begin
      state_d     = EMPTY;
      out_valid_d = 1'b0;
      out_data_d  = out_data_q;
      out_ctrl_d  = '0;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= EMPTY;
      out_valid_q <= 1'b0;
      out_data_q  <= RESET_DATA;
      out_ctrl_q  <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ctrl_q  <= out_ctrl_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ctrl  = out_ctrl_q;
  assign occupancy = 2'(state_q);

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg; expectations adapt to PIPE_STAGE_SKID_EN.
module tb_pipe_stage_reg;

  localparam logic [63:0] RESET_DATA_EXP = 64'h0040_0000_0000_0000;
`ifdef PIPE_STAGE_SKID_EN
  localparam int MAX_OCC    = 2;
  localparam int ACC_STALL  = 2;
  localparam int EXP_OCC[4] = '{1, 2, 2, 2};
  localparam int EXP_RDY[4] = '{1, 0, 0, 0};
`else
  localparam int MAX_OCC    = 1;
  localparam int ACC_STALL  = 1;
  localparam int EXP_OCC[4] = '{1, 1, 1, 1};
  localparam int EXP_RDY[4] = '{0, 0, 0, 0};
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_data = '0;
  logic [8:0]  in_ctrl = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_data;
  logic [8:0]  out_ctrl;
  logic [1:0]  occupancy;

  int n_checks = 0;
  int n_pass   = 0;
  int n_rel    = 0;
  logic [72:0] sb[$];

  pipe_stage_reg dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // One clock: book the handshake that the coming edge performs, then check invariants after it.
  task automatic cycle(output bit acc);
    logic [72:0] exp_e;
    logic [63:0] d_prev;
    logic [8:0]  c_prev;
    bit stall, idle;
    #1;
    acc    = (in_valid === 1'b1) && (in_ready === 1'b1) && !reset && !flush;
    stall  = (out_valid === 1'b1) && !out_ready && !reset && !flush;
    idle   = (out_valid === 1'b0) && !acc && !reset && !flush;
    d_prev = out_data;
    c_prev = out_ctrl;
    if (!reset) begin
      n_checks++;
      if (out_valid === 1'b0 && out_ctrl !== 9'd0)
        $display("FAIL bubble_ctrl: out_ctrl=%h required 0 while out_valid=0", out_ctrl);
      else if (occupancy > 2'(MAX_OCC))
        $display("FAIL occ_bound: occupancy=%0d required <=%0d", occupancy, MAX_OCC);
      else n_pass++;
    end
    if (reset || flush) sb.delete();
    else begin
      if (out_valid === 1'b1 && out_ready) begin
        n_rel++;
        n_checks++;
        if (sb.size() == 0)
          $display("FAIL sb_underflow: released data=%h ctrl=%h with nothing expected", out_data, out_ctrl);
        else begin
          exp_e = sb.pop_front();
          if ({out_data, out_ctrl} !== exp_e)
            $display("FAIL sb_order: got data=%h ctrl=%h required data=%h ctrl=%h",
                     out_data, out_ctrl, exp_e[72:9], exp_e[8:0]);
          else n_pass++;
        end
      end
      if (acc) sb.push_back({in_data, in_ctrl});
    end
    @(posedge clk);
    @(negedge clk);
    if (stall) begin
      n_checks++;
      if (out_data !== d_prev || out_ctrl !== c_prev || out_valid !== 1'b1)
        $display("FAIL stall_hold: got v=%b data=%h ctrl=%h required v=1 data=%h ctrl=%h",
                 out_valid, out_data, out_ctrl, d_prev, c_prev);
      else n_pass++;
    end
    if (idle) begin
      n_checks++;
      if (out_data !== d_prev || out_valid !== 1'b0)
        $display("FAIL idle_hold: got v=%b data=%h required v=0 data=%h", out_valid, out_data, d_prev);
      else n_pass++;
    end
  endtask

  task automatic check_after_reset(input string tag);
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_ctrl !== 9'd0 || out_data !== RESET_DATA_EXP ||
        occupancy !== 2'd0 || in_ready !== 1'b1)
      $display("FAIL %s: got v=%b ctrl=%h data=%h occ=%0d rdy=%b required v=0 ctrl=0 data=%h occ=0 rdy=1",
               tag, out_valid, out_ctrl, out_data, occupancy, in_ready, RESET_DATA_EXP);
    else n_pass++;
  endtask

  task automatic test_reset();
    bit a;
    @(negedge clk);
    reset = 1'b1; flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    in_data = 64'hFFFF_FFFF_FFFF_FFFF; in_ctrl = 9'h1FF;
    cycle(a);
    cycle(a);
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
    check_after_reset("reset_state");
  endtask

  task automatic test_stream();
    bit a;
    int rel0 = n_rel;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = 64'(i);
      in_ctrl  = 9'(i) | 9'h100;
      #1;
      n_checks++;
      if (in_ready !== 1'b1) $display("FAIL stream_ready[%0d]: in_ready=%b required 1", i, in_ready);
      else n_pass++;
      cycle(a);
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 64'(i) || out_ctrl !== (9'(i) | 9'h100))
        $display("FAIL stream_present[%0d]: got v=%b data=%h ctrl=%h required v=1 data=%h ctrl=%h",
                 i, out_valid, out_data, out_ctrl, 64'(i), 9'(i) | 9'h100);
      else n_pass++;
    end
    in_valid = 1'b0;
    cycle(a);
    n_checks++;
    if (out_valid !== 1'b0 || sb.size() != 0 || (n_rel - rel0) != 8)
      $display("FAIL stream_drain: got v=%b pending=%0d released=%0d required v=0 pending=0 released=8",
               out_valid, sb.size(), n_rel - rel0);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    bit a;
    int k = 0;
    int rel0 = n_rel;
    int budget = 20;
    logic [63:0] offers[3] = '{64'hA, 64'hB, 64'hC};
    out_ready = 1'b0;
    in_ctrl   = 9'h0AA;
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'b1;
      in_data  = offers[k];
      cycle(a);
      if (a) k++;
      n_checks++;
      if (occupancy !== 2'(EXP_OCC[c]) || in_ready !== 1'(EXP_RDY[c]) || out_data !== 64'hA)
        $display("FAIL bp_stall[%0d]: got occ=%0d rdy=%b data=%h required occ=%0d rdy=%0d data=a",
                 c, occupancy, in_ready, out_data, EXP_OCC[c], EXP_RDY[c]);
      else n_pass++;
    end
    n_checks++;
    if (k != ACC_STALL) $display("FAIL bp_accepts: got %0d required %0d", k, ACC_STALL);
    else n_pass++;
    out_ready = 1'b1;
    while ((k < 3 || sb.size() != 0 || out_valid === 1'b1) && budget > 0) begin
      in_valid = (k < 3);
      in_data  = (k < 3) ? offers[k] : 64'd0;
      cycle(a);
      if (a) k++;
      budget--;
    end
    in_valid = 1'b0;
    n_checks++;
    if (budget == 0 || (n_rel - rel0) != 3)
      $display("FAIL bp_drain: released=%0d budget_left=%0d required released=3 within budget",
               n_rel - rel0, budget);
    else n_pass++;
  endtask

  task automatic test_flush();
    bit a;
    out_ready = 1'b0;
    in_ctrl   = 9'h011;
    for (int c = 0; c < 2; c++) begin
      in_valid = 1'b1;
      in_data  = 64'h11 + 64'(c);
      cycle(a);
    end
    n_checks++;
    if (occupancy !== 2'(MAX_OCC)) $display("FAIL flush_fill: occ=%0d required %0d", occupancy, MAX_OCC);
    else n_pass++;
    flush = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
    in_data = 64'hDEAD; in_ctrl = 9'h155;
    cycle(a);
    flush = 1'b0; in_valid = 1'b0;
    n_checks++;
    if (occupancy !== 2'd0 || out_valid !== 1'b0 || out_ctrl !== 9'd0)
      $display("FAIL flush_clear: got occ=%0d v=%b ctrl=%h required occ=0 v=0 ctrl=0",
               occupancy, out_valid, out_ctrl);
    else n_pass++;
    for (int c = 0; c < 3; c++) begin
      cycle(a);
      n_checks++;
      if (out_valid !== 1'b0) $display("FAIL flush_dropped[%0d]: out_valid=%b required 0", c, out_valid);
      else n_pass++;
    end
  endtask

  task automatic test_bubble();
    bit a;
    in_valid = 1'b0;
    in_ctrl  = 9'h1FF;
    for (int c = 0; c < 3; c++) begin
      in_data   = {$urandom, $urandom};
      out_ready = c[0];
      cycle(a);
      n_checks++;
      if (out_valid !== 1'b0 || out_ctrl !== 9'd0)
        $display("FAIL bubble[%0d]: got v=%b ctrl=%h required v=0 ctrl=0", c, out_valid, out_ctrl);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_stall();
    bit a;
    out_ready = 1'b0;
    in_ctrl   = 9'h022;
    for (int c = 0; c < 2; c++) begin
      in_valid = 1'b1;
      in_data  = 64'h55 + 64'(c);
      cycle(a);
    end
    n_checks++;
    if (occupancy !== 2'(MAX_OCC)) $display("FAIL stall_fill: occ=%0d required %0d", occupancy, MAX_OCC);
    else n_pass++;
    reset = 1'b1; flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    cycle(a);
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
    check_after_reset("reset_mid_stall");
  endtask

  task automatic test_random();
    bit a;
    int budget = 20;
    for (int c = 0; c < 300; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      in_data   = {$urandom, $urandom};
      in_ctrl   = 9'($urandom);
      cycle(a);
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    while ((sb.size() != 0 || out_valid === 1'b1) && budget > 0) begin
      cycle(a);
      budget--;
    end
    n_checks++;
    if (budget == 0 || sb.size() != 0)
      $display("FAIL random_drain: pending=%0d budget_left=%0d required pending=0", sb.size(), budget);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_bubble();
    test_reset_mid_stall();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
